cpu_status_intr: RTL

//  Processor status register (P) and interrupt-pending logic for the 2A03 CPU core, directly downstream of the ALU.

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/cpu_nmi_latch.sv | 39 +++
 rtl/cpu_status_intr.sv | 138 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 2A03 status register block.
package cpu_pkg;

  typedef enum logic [2:0] {
    FOP_NONE = 3'd0,
    FOP_CLC  = 3'd1,
    FOP_SEC  = 3'd2,
    FOP_CLI  = 3'd3,
    FOP_SEI  = 3'd4,
    FOP_CLV  = 3'd5,
    FOP_CLD  = 3'd6,
    FOP_SED  = 3'd7
  } ctrl_flag_op_t;

  // Bit positions inside the architectural P byte.
  localparam int P_C = 0;
  localparam int P_Z = 1;
  localparam int P_I = 2;
  localparam int P_D = 3;
  localparam int P_B = 4;
  localparam int P_U = 5;
  localparam int P_V = 6;
  localparam int P_N = 7;

  // Branch flag selectors taken from opcode[7:6].
  localparam logic [1:0] BR_SEL_N = 2'b00;
  localparam logic [1:0] BR_SEL_V = 2'b01;
  localparam logic [1:0] BR_SEL_C = 2'b10;
  localparam logic [1:0] BR_SEL_Z = 2'b11;

  localparam logic [7:0] P_RESET_DEFAULT = 8'h24;

endpackage

// File: rtl/cpu_nmi_latch.sv
// NMI falling-edge detector and pending latch; a new edge beats a coincident ack.
module cpu_nmi_latch
  import cpu_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic nmi_n,
  input  logic nmi_ack,
  output logic nmi_pending
);

  logic nmi_prev_q, nmi_prev_d;
  logic nmi_latch_q, nmi_latch_d;
  logic nmi_edge;

  always_comb begin
    nmi_edge    = nmi_prev_q & ~nmi_n;
    nmi_prev_d  = nmi_n;
    nmi_latch_d = nmi_latch_q;
    if (nmi_edge) begin
      nmi_latch_d = 1'b1;
    end else if (nmi_ack) begin
      nmi_latch_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      nmi_prev_q  <= 1'b1;
      nmi_latch_q <= 1'b0;
    end else begin
      nmi_prev_q  <= nmi_prev_d;
      nmi_latch_q <= nmi_latch_d;
    end
  end

  assign nmi_pending = nmi_latch_q;

endmodule

// File: rtl/cpu_status_intr.sv
// 2A03 processor status register P, branch evaluation and NMI/IRQ qualification.
module cpu_status_intr
  import cpu_pkg::*;
#(
  parameter logic [7:0] P_RESET = P_RESET_DEFAULT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       alu_n,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_mode,
  input  logic [7:0] r_data,
  input  logic       load_p,
  input  logic [2:0] flag_op,
  input  logic       push_brk,
  input  logic [2:0] branch_cond,
  input  logic       nmi_n,
  input  logic       irq_n,
  input  logic       nmi_ack,
  output logic [7:0] p_out,
  output logic       c_flag,
  output logic       i_flag,
  output logic       branch_taken,
  output logic       nmi_pending,
  output logic       irq_pending
);

  ctrl_flag_op_t fop;
  logic n_q, v_q, d_q, i_q, z_q, c_q, irq_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d, irq_d;
  logic sel_flag;
  logic unused_rdata_bits;

  assign fop = ctrl_flag_op_t'(flag_op);
  // B and the constant-one bit are not stored; PLP/RTI drop them.
  assign unused_rdata_bits = ^r_data[P_U:P_B];

  // Per-flag priority: load_p > flag_op > bit_mode > ALU enable > hold.
  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (load_p) begin
      n_d = r_data[P_N];
      v_d = r_data[P_V];
      d_d = r_data[P_D];
      i_d = r_data[P_I];
      z_d = r_data[P_Z];
      c_d = r_data[P_C];
    end else begin
      if (bit_mode)    n_d = r_data[7];
      else if (upd_nz) n_d = alu_n;

      if (fop == FOP_CLV) v_d = 1'b0;
      else if (bit_mode)  v_d = r_data[6];
      else if (upd_v)     v_d = alu_v;

      if (bit_mode || upd_nz) z_d = alu_z;

      if (fop == FOP_CLC)      c_d = 1'b0;
      else if (fop == FOP_SEC) c_d = 1'b1;
      else if (upd_c)          c_d = alu_c;

      if (fop == FOP_CLI)      i_d = 1'b0;
      else if (fop == FOP_SEI) i_d = 1'b1;

      if (fop == FOP_CLD)      d_d = 1'b0;
      else if (fop == FOP_SED) d_d = 1'b1;
    end
    // Masking uses the pre-update I, giving the 6502 one-cycle poll lag.
    irq_d = ~irq_n & ~i_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      n_q   <= P_RESET[P_N];
      v_q   <= P_RESET[P_V];
      d_q   <= P_RESET[P_D];
      i_q   <= P_RESET[P_I];
      z_q   <= P_RESET[P_Z];
      c_q   <= P_RESET[P_C];
      irq_q <= 1'b0;
    end else begin
      n_q   <= n_d;
      v_q   <= v_d;
      d_q   <= d_d;
      i_q   <= i_d;
      z_q   <= z_d;
      c_q   <= c_d;
      irq_q <= irq_d;
    end
  end

  always_comb begin
    p_out      = 8'h00;
    p_out[P_N] = n_q;
    p_out[P_V] = v_q;
    p_out[P_U] = 1'b1;
    p_out[P_B] = push_brk;
    p_out[P_D] = d_q;
    p_out[P_I] = i_q;
    p_out[P_Z] = z_q;
    p_out[P_C] = c_q;
  end

  always_comb begin
    sel_flag = 1'b0;
    case (branch_cond[2:1])
      BR_SEL_N: sel_flag = n_q;
      BR_SEL_V: sel_flag = v_q;
      BR_SEL_C: sel_flag = c_q;
      BR_SEL_Z: sel_flag = z_q;
      default:  sel_flag = 1'b0;
    endcase
    branch_taken = (sel_flag == branch_cond[0]);
  end

  assign c_flag      = c_q;
  assign i_flag      = i_q;
  assign irq_pending = irq_q;

  cpu_nmi_latch u_nmi (
    .clock       (clock),
    .reset_n     (reset_n),
    .nmi_n       (nmi_n),
    .nmi_ack     (nmi_ack),
    .nmi_pending (nmi_pending)
  );

endmodule
